// File: rtl/decoration_sequencer.sv
// decoration_sequencer
//   Walks the 4-channel opcode bank of the Halloween decoration and decodes
//   each opcode into colour, sound and movement actions. The 2-bit channel
//   pointer (select) drives the channel mux. Sound uses a req/ack handshake
//   with a timeout. A movement request is held for DWELL cycles.
//
// Ports
//   clk, rst_n      clock (rising edge), async active-low reset
//   start, stop     begin a pass at channel 0 / synchronous abort to idle
//   loop            1 = wrap from channel 3 back to 0, 0 = end after channel 3
//   data_in[15:0]   opcode bank, channel n = data_in[4n+3:4n]
//   ch_valid[3:0]   per-channel enable; invalid channels are skipped
//   sound_ack       sound unit accepted the request
//   select[1:0]     current channel pointer
//   busy            high whenever the sequencer is not idle
//   armed           set by ON, cleared by RESET
//   color[1:0], color_valid   decoded colour
//   sound_req, sound_id[1:0]  sound request, id stable while req is high
//   move_req[2:0]   one-hot movement: [0] wave, [1] jaw, [2] fog
//   err             sticky: illegal opcode or ack timeout
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start
// SCAN     | test ch_valid[select], latch the opcode or skip the channel
// EXEC     | decode the latched opcode and act on it
// WAIT_ACK | sound_req high, waiting for sound_ack or timeout
// HOLD     | move_req high for the dwell time
module decoration_sequencer #(
  parameter int DWELL       = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        loop,
  input  logic [15:0] data_in,
  input  logic [3:0]  ch_valid,
  input  logic        sound_ack,
  output logic [1:0]  select,
  output logic        busy,
  output logic        armed,
  output logic [1:0]  color,
  output logic        color_valid,
  output logic        sound_req,
  output logic [1:0]  sound_id,
  output logic [2:0]  move_req,
  output logic        err
);

  localparam int TMAX = (DWELL > ACK_TIMEOUT) ? DWELL : ACK_TIMEOUT;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  // Both timers are down-counters: loaded with N-1, terminal count at 0.
  // For the ack wait this is equivalent to counting up from 0 to ACK_TIMEOUT-1.
  localparam logic [TW-1:0] ACK_LOAD   = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] DWELL_LOAD = TW'(DWELL - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_EXEC,
    S_WAIT_ACK,
    S_HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      select_q, select_d;
  logic [3:0]      op_q, op_d;
  logic            armed_q, armed_d;
  logic [1:0]      color_q, color_d;
  logic            color_valid_q, color_valid_d;
  logic            sound_req_q, sound_req_d;
  logic [1:0]      sound_id_q, sound_id_d;
  logic [2:0]      move_req_q, move_req_d;
  logic            err_q, err_d;
  logic [TW-1:0]   timer_q, timer_d;

  logic [1:0] op_class;
  logic [1:0] op_code;
  logic       op_illegal;
  logic       advance;

  assign op_class   = op_q[3:2];
  assign op_code    = op_q[1:0];
  assign op_illegal = (op_code == 2'b11) || ((op_class == 2'b00) && (op_code == 2'b10));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      select_q      <= 2'd0;
      op_q          <= 4'd0;
      armed_q       <= 1'b0;
      color_q       <= 2'd0;
      color_valid_q <= 1'b0;
      sound_req_q   <= 1'b0;
      sound_id_q    <= 2'd0;
      move_req_q    <= 3'd0;
      err_q         <= 1'b0;
      timer_q       <= '0;
    end else begin
      state_q       <= state_d;
      select_q      <= select_d;
      op_q          <= op_d;
      armed_q       <= armed_d;
      color_q       <= color_d;
      color_valid_q <= color_valid_d;
      sound_req_q   <= sound_req_d;
      sound_id_q    <= sound_id_d;
      move_req_q    <= move_req_d;
      err_q         <= err_d;
      timer_q       <= timer_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    select_d      = select_q;
    op_d          = op_q;
    armed_d       = armed_q;
    color_d       = color_q;
    color_valid_d = color_valid_q;
    sound_req_d   = sound_req_q;
    sound_id_d    = sound_id_q;
    move_req_d    = move_req_q;
    err_d         = err_q;
    timer_d       = timer_q;
    advance       = 1'b0;

    if (stop && (state_q != S_IDLE)) begin
      // Abort wins over everything; armed/colour/err are left untouched.
      state_d     = S_IDLE;
      sound_req_d = 1'b0;
      move_req_d  = 3'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !stop) begin
            select_d = 2'd0;
            err_d    = 1'b0;
            state_d  = S_SCAN;
          end
        end

        S_SCAN: begin
          if (ch_valid[select_q]) begin
            op_d    = data_in[{select_q, 2'b00} +: 4];
            state_d = S_EXEC;
          end else begin
            advance = 1'b1;
          end
        end

        S_EXEC: begin
          if (op_q == 4'b0000) begin
            armed_d = 1'b1;
            advance = 1'b1;
          end else if (op_q == 4'b0001) begin
            // RESET ends the pass immediately; select keeps its value.
            armed_d       = 1'b0;
            color_valid_d = 1'b0;
            color_d       = 2'd0;
            state_d       = S_IDLE;
          end else if (op_illegal) begin
            err_d   = 1'b1;
            advance = 1'b1;
          end else if (!armed_q) begin
            advance = 1'b1;
          end else begin
            case (op_class)
              2'b01: begin
                color_d       = op_code;
                color_valid_d = 1'b1;
                advance       = 1'b1;
              end
              2'b10: begin
                sound_req_d = 1'b1;
                sound_id_d  = op_code;
                timer_d     = ACK_LOAD;
                state_d     = S_WAIT_ACK;
              end
              2'b11: begin
                move_req_d = 3'b001 << op_code;
                timer_d    = DWELL_LOAD;
                state_d    = S_HOLD;
              end
              default: advance = 1'b1;
            endcase
          end
        end

        S_WAIT_ACK: begin
          // An ack on the terminal cycle takes priority over the timeout.
          if (sound_ack) begin
            sound_req_d = 1'b0;
            advance     = 1'b1;
          end else if (timer_q == '0) begin
            sound_req_d = 1'b0;
            err_d       = 1'b1;
            advance     = 1'b1;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end

        S_HOLD: begin
          if (timer_q == '0) begin
            move_req_d = 3'd0;
            advance    = 1'b1;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end

        default: state_d = S_IDLE;
      endcase

      if (advance) begin
        if ((select_q == 2'd3) && !loop) begin
          state_d = S_IDLE;
        end else begin
          select_d = select_q + 2'd1;
          state_d  = S_SCAN;
        end
      end
    end
  end

  assign select      = select_q;
  assign busy        = (state_q != S_IDLE);
  assign armed       = armed_q;
  assign color       = color_q;
  assign color_valid = color_valid_q;
  assign sound_req   = sound_req_q;
  assign sound_id    = sound_id_q;
  assign move_req    = move_req_q;
  assign err         = err_q;

endmodule

// File: tb/tb_decoration_sequencer.sv
// Directed bench for decoration_sequencer. Inputs change 1 time unit after
// the rising edge, outputs are sampled at that same point.
module tb_decoration_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic        loop;
  logic [15:0] data_in;
  logic [3:0]  ch_valid;
  logic        sound_ack;
  logic [1:0]  select;
  logic        busy;
  logic        armed;
  logic [1:0]  color;
  logic        color_valid;
  logic        sound_req;
  logic [1:0]  sound_id;
  logic [2:0]  move_req;
  logic        err;

  decoration_sequencer #(.DWELL(4), .ACK_TIMEOUT(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .loop        (loop),
    .data_in     (data_in),
    .ch_valid    (ch_valid),
    .sound_ack   (sound_ack),
    .select      (select),
    .busy        (busy),
    .armed       (armed),
    .color       (color),
    .color_valid (color_valid),
    .sound_req   (sound_req),
    .sound_id    (sound_id),
    .move_req    (move_req),
    .err         (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // per-pass observations
  int         ack_after = 0;
  int         sreq_run;
  int         cyc;
  int         n_sreq;
  int         n_mreq;
  logic [2:0] mval;
  logic [1:0] id_seen;
  logic       cv_seen;

  task automatic sample();
    if (busy) cyc++;
    if (sound_req) begin
      n_sreq++;
      sreq_run++;
      id_seen = sound_id;
    end else begin
      sreq_run = 0;
    end
    if (move_req != 3'd0) n_mreq++;
    mval = mval | move_req;
    if (color_valid) cv_seen = 1'b1;
    sound_ack = (ack_after > 0) && (sreq_run >= ack_after);
  endtask

  task automatic do_start();
    cyc = 0; n_sreq = 0; n_mreq = 0; sreq_run = 0;
    mval = 3'd0; id_seen = 2'b11; cv_seen = 1'b0;
    sound_ack = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    sample();
  endtask

  task automatic run_pass(input string tag);
    int guard = 0;
    while (busy && guard < 200) begin
      tick();
      sample();
      guard++;
    end
    sound_ack = 1'b0;
    if (guard >= 200) chk({tag, "_budget"}, busy, 0);
  endtask

  logic [1:0] sel_exp [9] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd3, 2'd0, 2'd0, 2'd1};

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0;
    data_in = 16'h0000; ch_valid = 4'h0; sound_ack = 1'b0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_select", select, 0);
    chk("rst_armed", armed, 0);
    chk("rst_color", {color_valid, color}, 0);
    chk("rst_sound", {sound_req, sound_id}, 0);
    chk("rst_move", move_req, 0);
    chk("rst_err", err, 0);
    #1 rst_n = 1'b1;

    // unarmed pass: everything but ON is a no-op
    data_in = 16'h058D; ch_valid = 4'hF; loop = 1'b0;
    do_start();
    chk("p1_busy_start", busy, 1);
    run_pass("p1");
    chk("p1_cycles", cyc, 8);
    chk("p1_sreq", n_sreq, 0);
    chk("p1_mreq", n_mreq, 0);
    chk("p1_cv", cv_seen, 0);
    chk("p1_armed", armed, 1);
    chk("p1_select", select, 3);

    // armed pass, ack 3 cycles after req
    ack_after = 3;
    do_start();
    run_pass("p2");
    chk("p2_cycles", cyc, 15);
    chk("p2_mreq_cnt", n_mreq, 4);
    chk("p2_mreq_val", mval, 3'b010);
    chk("p2_sreq_cnt", n_sreq, 3);
    chk("p2_sound_id", id_seen, 2'b00);
    chk("p2_color", {color_valid, color}, 3'b101);
    chk("p2_armed", armed, 1);
    chk("p2_select", select, 3);
    chk("p2_err", err, 0);
    ack_after = 0;

    // ack timeout
    data_in = 16'h000A; ch_valid = 4'h1;
    do_start();
    run_pass("p3");
    chk("p3_cycles", cyc, 21);
    chk("p3_sreq_cnt", n_sreq, 16);
    chk("p3_sound_id", id_seen, 2'b10);
    chk("p3_err", err, 1);
    chk("p3_sreq_end", sound_req, 0);
    ch_valid = 4'h0;
    do_start();
    chk("p3_err_clr", err, 0);
    run_pass("p3b");
    chk("p3b_cycles", cyc, 4);

    // set orange, then illegal + RESET
    data_in = 16'h0006; ch_valid = 4'h1;
    do_start();
    run_pass("p4a");
    chk("p4a_cycles", cyc, 5);
    chk("p4a_color", {color_valid, color}, 3'b110);
    data_in = 16'h0017; ch_valid = 4'hF;
    do_start();
    tick(); tick();
    chk("p4_err", err, 1);
    chk("p4_armed_mid", armed, 1);
    chk("p4_color_mid", color, 2'b10);
    tick(); tick();
    chk("p4_busy", busy, 0);
    chk("p4_armed", armed, 0);
    chk("p4_color", {color_valid, color}, 0);
    chk("p4_select", select, 1);
    chk("p4_err_keep", err, 1);

    // loop with skipped channels; start held high is ignored while busy
    data_in = 16'h0500; ch_valid = 4'h5; loop = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("p5_sel%0d", i), select, sel_exp[i]);
    end
    chk("p5_color", {color_valid, color}, 3'b101);
    start = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("p5_stop_busy", busy, 0);

    // stop during HOLD
    data_in = 16'h000E; ch_valid = 4'h1;
    do_start();
    tick(); tick();
    chk("p6_mreq", move_req, 3'b100);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("p6_mreq_stop", move_req, 0);
    chk("p6_busy", busy, 0);
    chk("p6_armed", armed, 1);
    chk("p6_color", {color_valid, color}, 3'b101);

    // async reset during WAIT_ACK
    data_in = 16'h0009; ch_valid = 4'h1; loop = 1'b0;
    do_start();
    tick(); tick();
    chk("p7_sreq", {sound_req, sound_id}, 3'b101);
    #2 rst_n = 1'b0;
    #1;
    chk("p7_rst_sreq", sound_req, 0);
    chk("p7_rst_busy", busy, 0);
    chk("p7_rst_armed", armed, 0);
    #3 rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
